// File: rtl/gun_flash_seq_if.sv
// Signal bundle between the trigger/input logic, gun_flash_seq and the draw stage.
// Optional cheat_flag exists only when GUN_FLASH_CHEAT_CHECK_EN is defined.
interface gun_flash_seq_if;
  logic frame_start;
  logic gun_is_connected;
  logic gun_trigger;
  logic gun_photodetector;
  logic flash_black;
  logic flash_target;
  logic busy;
  logic hit;
  logic miss;
`ifdef GUN_FLASH_CHEAT_CHECK_EN
  logic cheat_flag;

  modport master (
    output frame_start, gun_is_connected, gun_trigger, gun_photodetector,
    input  flash_black, flash_target, busy, hit, miss, cheat_flag
  );
  modport slave (
    input  frame_start, gun_is_connected, gun_trigger, gun_photodetector,
    output flash_black, flash_target, busy, hit, miss, cheat_flag
  );
`else
  modport master (
    output frame_start, gun_is_connected, gun_trigger, gun_photodetector,
    input  flash_black, flash_target, busy, hit, miss
  );
  modport slave (
    input  frame_start, gun_is_connected, gun_trigger, gun_photodetector,
    output flash_black, flash_target, busy, hit, miss
  );
`endif
endinterface

// File: rtl/gun_flash_seq.sv
// Light-gun flash sequencer: trigger pull -> one black frame -> TARGET_FRAMES lit frames -> hit/miss.
// Define GUN_FLASH_CHEAT_CHECK_EN to flag light seen during the black frame as a cheat.
module gun_flash_seq #(
  parameter int unsigned TARGET_FRAMES   = 1,
  parameter int unsigned COOLDOWN_FRAMES = 2,
  parameter int unsigned PD_MIN_CYCLES   = 16
) (
  input  logic           clk,
  input  logic           rst,
  gun_flash_seq_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0,
                         ST_ARM      = 3'd1,
                         ST_BLACK    = 3'd2,
                         ST_TARGET   = 3'd3,
                         ST_RESULT   = 3'd4,
                         ST_COOLDOWN = 3'd5;

  localparam logic [2:0] TGT_LAST     = 3'(TARGET_FRAMES - 1);
  localparam logic [2:0] CD_LAST      = 3'(COOLDOWN_FRAMES - 1);
  localparam bit         HAS_COOLDOWN = (COOLDOWN_FRAMES != 0);
  localparam logic [7:0] PD_MIN       = 8'(PD_MIN_CYCLES);

  logic       trig_meta_q, trig_sync_q, trig_prev_q;
  logic       pd_meta_q, pd_sync_q;
  logic [2:0] state_q, state_d;
  logic [2:0] frm_q, frm_d;
  logic [7:0] run_cnt_q, run_cnt_d, run_cnt_inc;
  logic       light_seen_q, light_seen_d, seen_nxt;
  logic       tgt_hit_q, tgt_hit_d;
  logic       shot_event;
  logic       in_result;

  // NOTE: every flop uses <= so all of them sample pre-edge values; blocking
  // assignments here would make the synchronizer collapse into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Trigger is negative logic: reset to "not pulled" so leaving reset with
      // the trigger released can never look like a falling edge.
      trig_meta_q <= 1'b1;
      trig_sync_q <= 1'b1;
      trig_prev_q <= 1'b1;
      pd_meta_q   <= 1'b0;
      pd_sync_q   <= 1'b0;
    end else begin
      trig_meta_q <= bus.gun_trigger;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
      pd_meta_q   <= bus.gun_photodetector;
      pd_sync_q   <= pd_meta_q;
    end
  end

  assign shot_event = trig_prev_q & ~trig_sync_q & bus.gun_is_connected &
                      (state_q == ST_IDLE);

  // Run-length light detector; seen_nxt is the flag as it will be after this edge.
  always_comb begin
    if (!pd_sync_q)             run_cnt_inc = 8'd0;
    else if (run_cnt_q >= PD_MIN) run_cnt_inc = PD_MIN;
    else                        run_cnt_inc = run_cnt_q + 8'd1;
  end

  assign seen_nxt = light_seen_q | (run_cnt_inc == PD_MIN);

  // NOTE: each always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    frm_d     = frm_q;
    tgt_hit_d = tgt_hit_q;
    case (state_q)
      ST_IDLE: begin
        if (shot_event) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.frame_start) state_d = ST_BLACK;
      end
      ST_BLACK: begin
        if (bus.frame_start) begin
          state_d = ST_TARGET;
          frm_d   = 3'd0;
        end
      end
      ST_TARGET: begin
        if (bus.frame_start) begin
          if (frm_q == TGT_LAST) begin
            state_d   = ST_RESULT;
            tgt_hit_d = seen_nxt;
          end else begin
            frm_d = frm_q + 3'd1;
          end
        end
      end
      ST_RESULT: begin
        frm_d   = 3'd0;
        state_d = HAS_COOLDOWN ? ST_COOLDOWN : ST_IDLE;
      end
      ST_COOLDOWN: begin
        if (bus.frame_start) begin
          if (frm_q == CD_LAST) state_d = ST_IDLE;
          else                  frm_d   = frm_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing the gun abandons the shot silently from any active state.
    if ((state_q != ST_IDLE) && !bus.gun_is_connected) state_d = ST_IDLE;
  end

  // The detector restarts on every state change so each phase is judged alone.
  always_comb begin
    if (state_d != state_q) begin
      run_cnt_d    = 8'd0;
      light_seen_d = 1'b0;
    end else begin
      run_cnt_d    = run_cnt_inc;
      light_seen_d = seen_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      frm_q        <= 3'd0;
      run_cnt_q    <= 8'd0;
      light_seen_q <= 1'b0;
      tgt_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frm_q        <= frm_d;
      run_cnt_q    <= run_cnt_d;
      light_seen_q <= light_seen_d;
      tgt_hit_q    <= tgt_hit_d;
    end
  end

  assign in_result        = (state_q == ST_RESULT);
  assign bus.flash_black  = (state_q == ST_BLACK);
  assign bus.flash_target = (state_q == ST_TARGET);
  assign bus.busy         = (state_q != ST_IDLE);

`ifdef GUN_FLASH_CHEAT_CHECK_EN
  logic cheat_q, cheat_d;

  // Light while the screen is forced black cannot come from the target.
  always_comb begin
    cheat_d = cheat_q;
    if (state_q == ST_IDLE)                   cheat_d = 1'b0;
    else if ((state_q == ST_BLACK) && seen_nxt) cheat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cheat_q <= 1'b0;
    else      cheat_q <= cheat_d;
  end

  assign bus.hit        = in_result & tgt_hit_q & ~cheat_q;
  assign bus.miss       = in_result & (~tgt_hit_q | cheat_q);
  assign bus.cheat_flag = in_result & cheat_q;
`else
  assign bus.hit  = in_result & tgt_hit_q;
  assign bus.miss = in_result & ~tgt_hit_q;
`endif

endmodule

// File: doc/gun_flash_seq.md
Name: gun_flash_seq

Overview:
- Display-side counterpart of the light-gun input path: converts a trigger pull into the frame-synchronous flash sequence the photodetector needs to see.
- Sequence is one all-black frame, then TARGET_FRAMES frames with the target drawn white on black.
- Judges the synchronized photodetector during those frames and emits one-cycle hit/miss pulses.
- Sits between the trigger/input logic and the draw pipeline; the draw stage uses flash_black/flash_target to override pixel colour.

Parameters:
- TARGET_FRAMES, 1, number of consecutive target-lit frames (1..7).
- COOLDOWN_FRAMES, 2, frames after a result before a new shot is accepted (0..7).
- PD_MIN_CYCLES, 16, consecutive synchronized-high photodetector cycles that count as "light seen" (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- frame_start  in  1  one-cycle pulse at start of each video frame (vsync-derived).
- gun_is_connected  in  1  level, gun peripheral present.
- gun_trigger  in  1  raw trigger, negative logic (0 = pulled).
- gun_photodetector  in  1  raw photodiode, 1 = light seen.
- flash_black  out  1  force whole screen black.
- flash_target  out  1  draw target white, rest of screen black.
- busy  out  1  sequence in progress (any state but IDLE).
- hit  out  1  one-cycle pulse, target light detected.
- miss  out  1  one-cycle pulse, shot judged a miss.

Behaviour:
- Reset: state IDLE; flash_black=0, flash_target=0, busy=0, hit=0, miss=0; all counters and flags 0. Trigger edge-detect register resets to 1 (not pulled).
- gun_trigger and gun_photodetector each pass through a 2-flop synchronizer before use.
- Shot event: synchronized trigger falls 1->0 while gun_is_connected=1 and state=IDLE. Events in any other state are ignored, not queued.
- Light detector:
  - run counter increments on each cycle photodetector=1 and clears on 0; saturates at PD_MIN_CYCLES.
  - light_seen flag sets when the counter reaches PD_MIN_CYCLES.
  - Counter and flag clear on every state entry.
- States:
  - IDLE: outputs low; shot event -> ARM.
  - ARM: busy=1; waits for the next frame_start -> BLACK. A frame_start in the same cycle as the shot event does not count.
  - BLACK: flash_black=1 for one full frame; next frame_start -> TARGET, frame counter=0.
  - TARGET: flash_target=1. On each frame_start: if frame counter = TARGET_FRAMES-1 -> RESULT, else increment.
  - RESULT: exactly one cycle. hit=1 if light_seen was set at any point in TARGET, else miss=1. Then -> COOLDOWN, or IDLE if COOLDOWN_FRAMES=0.
  - COOLDOWN: busy=1, flash outputs 0; counts COOLDOWN_FRAMES frame_start pulses, then -> IDLE.
- Latency: hit/miss is asserted the cycle after the frame_start that ends the last TARGET frame.
- hit and miss are never asserted together; exactly one pulses per completed shot.
- gun_is_connected dropping in any non-IDLE state: abort to IDLE next cycle, flash outputs drop, no hit/miss pulse.
- frame_start is assumed never to arrive on two consecutive cycles; behaviour in that case is undefined.
- Async reset mid-sequence: outputs immediately return to reset values.

Optional Feature:
- Macro GUN_FLASH_CHEAT_CHECK_EN.
- When defined: light_seen set during BLACK is latched as cheat. RESULT then issues miss regardless of the TARGET result, and a cheat_flag output (1 bit) pulses together with that miss.
- When undefined: photodetector is ignored during BLACK, and no cheat_flag port exists.

Test Plan:
- Reset: hold rst=0 with gun_trigger=0 toggling -> all outputs 0. Release rst -> no shot until a 1->0 trigger transition.
- Hit: gun_is_connected=1, frames of 1000 cycles, trigger falls at cycle 100, photodetector high for 20 cycles in TARGET frame (PD_MIN_CYCLES=16):
  - flash_black high for exactly 1000 cycles, then flash_target for 1000 cycles.
  - hit=1 for one cycle after the frame_start that ends TARGET.
- Miss / noise: photodetector high for only 15 cycles in TARGET -> miss=1 one cycle, hit=0. Second trigger during COOLDOWN is ignored; busy clears after 2 frame_start pulses.
- Coincidence: trigger edge and frame_start in the same cycle -> flash_black asserts only at the following frame_start.
- Abort: gun_is_connected deasserted mid-TARGET -> IDLE next cycle, flash_target=0, no hit/miss.
- Cheat (GUN_FLASH_CHEAT_CHECK_EN): photodetector high 30 cycles in BLACK and 30 in TARGET -> miss=1 and cheat_flag=1, hit=0.
